// File: rtl/phy_utx_pkg.sv
// Buffers package words in a FIFO and serialises each as 8N1 UART bytes: optional 0xA5 header, data bytes, optional checksum.
// Two edges from accept to start bit; pkg_rdy drops when the FIFO is full and offered words are then dropped, setting ovf.
module phy_utx_pkg #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int BAUD_DIV  = 434,
  parameter int FRAME_EN  = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk_sys,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        pkg_d,
  input  logic                     pkg_vld,
  output logic                     pkg_rdy,
  output logic                     pkg_done,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic                     uart_tx
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam int NDB    = DATA_W / 8;
  localparam int FR     = (FRAME_EN != 0) ? 1 : 0;
  localparam int NB     = NDB + 2 * FR;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, DONE} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [2:0]        byte_idx_q, byte_idx_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic              uart_tx_q, uart_tx_d;
  logic              done_q, done_d;
  logic              push, pop, baud_end;
  logic [2:0]        di;
  logic [7:0]        csum, cur_byte;

  assign pkg_rdy  = (cnt_q < CNT_W'(DEPTH));
  assign push     = pkg_vld && pkg_rdy;
  assign pop      = (state_q == LOAD);
  assign fifo_cnt = cnt_q;
  assign ovf      = ovf_q;
  assign uart_tx  = uart_tx_q;
  assign pkg_done = done_q;
  assign baud_end = (baud_cnt_q == BAUD_W'(BAUD_DIV - 1));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    // Clear beats a same-cycle overflow so software never loses its acknowledge.
    if (ovf_clr)                  ovf_d = 1'b0;
    else if (pkg_vld && !pkg_rdy) ovf_d = 1'b1;
  end

  always_comb begin
    csum     = 8'h00;
    cur_byte = 8'h00;
    di       = byte_idx_q - 3'(FR);
    for (int j = 0; j < NDB; j++) begin
      csum = csum + word_q[8*j +: 8];
      if (di == 3'(j))
        cur_byte = (MSB_FIRST != 0) ? word_q[DATA_W-8-8*j +: 8] : word_q[8*j +: 8];
    end
    if (FR != 0 && byte_idx_q == 3'd0)        cur_byte = 8'hA5;
    if (FR != 0 && byte_idx_q == 3'(NB - 1))  cur_byte = csum;
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    baud_cnt_d = baud_cnt_q;
    case (state_q)
      IDLE: if (cnt_q != '0) state_d = LOAD;
      LOAD: begin
        word_d     = mem_q[rd_ptr_q];
        byte_idx_d = 3'd0;
        baud_cnt_d = '0;
        state_d    = START;
      end
      START: begin
        baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        if (baud_end) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          state_d    = DATA;
        end
      end
      DATA: begin
        baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        if (baud_end) begin
          baud_cnt_d = '0;
          if (byte_idx_q == 3'(NB - 1)) begin
            state_d = DONE;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = START;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Line level is decoded from the next state so the pin is a plain flop.
    uart_tx_d = 1'b1;
    if (state_d == START)     uart_tx_d = 1'b0;
    else if (state_d == DATA) uart_tx_d = cur_byte[bit_idx_d];
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst && push) mem_q[wr_ptr_q] <= pkg_d;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      state_q    <= IDLE;
      word_q     <= '0;
      byte_idx_q <= 3'd0;
      bit_idx_q  <= 3'd0;
      baud_cnt_q <= '0;
      uart_tx_q  <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      uart_tx_q  <= uart_tx_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_phy_utx_pkg.sv
// Three configurations of phy_utx_pkg share one clock; a UART decoder on the selected line pops an expected-byte scoreboard.
module tb_phy_utx_pkg;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        rst, ovf_clr;
  logic [15:0] a_d, b_d;
  logic [31:0] c_d;
  logic        a_vld, b_vld, c_vld;
  logic        a_rdy, b_rdy, c_rdy;
  logic        a_done, b_done, c_done;
  logic [2:0]  a_cnt, b_cnt, c_cnt;
  logic        a_ovf, b_ovf, c_ovf;
  logic        a_tx, b_tx, c_tx;

  phy_utx_pkg #(.DATA_W(16), .DEPTH(4), .BAUD_DIV(4), .FRAME_EN(1), .MSB_FIRST(1)) dut_a (
    .clk_sys(clk_sys), .rst(rst), .pkg_d(a_d), .pkg_vld(a_vld), .pkg_rdy(a_rdy),
    .pkg_done(a_done), .fifo_cnt(a_cnt), .ovf(a_ovf), .ovf_clr(ovf_clr), .uart_tx(a_tx));
  phy_utx_pkg #(.DATA_W(16), .DEPTH(4), .BAUD_DIV(4), .FRAME_EN(0), .MSB_FIRST(0)) dut_b (
    .clk_sys(clk_sys), .rst(rst), .pkg_d(b_d), .pkg_vld(b_vld), .pkg_rdy(b_rdy),
    .pkg_done(b_done), .fifo_cnt(b_cnt), .ovf(b_ovf), .ovf_clr(ovf_clr), .uart_tx(b_tx));
  phy_utx_pkg #(.DATA_W(32), .DEPTH(4), .BAUD_DIV(2), .FRAME_EN(1), .MSB_FIRST(1)) dut_c (
    .clk_sys(clk_sys), .rst(rst), .pkg_d(c_d), .pkg_vld(c_vld), .pkg_rdy(c_rdy),
    .pkg_done(c_done), .fifo_cnt(c_cnt), .ovf(c_ovf), .ovf_clr(ovf_clr), .uart_tx(c_tx));

  int   sel = 0;
  int   baud_m = 4;
  logic tx_m, done_m;
  assign tx_m   = (sel == 2) ? c_tx   : (sel == 1) ? b_tx   : a_tx;
  assign done_m = (sel == 2) ? c_done : (sel == 1) ? b_done : a_done;

  int         n_chk = 0;
  int         n_pass = 0;
  int         n_done = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;
  bit         mon_busy = 1'b0;
  int         mon_cyc = 0;
  logic [7:0] rx_byte;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w, input int nbytes, input bit frame, input bit msb);
    logic [7:0] b;
    logic [7:0] sum;
    sum = 8'h00;
    if (frame) exp_q.push_back(8'hA5);
    for (int j = 0; j < nbytes; j++) begin
      b = msb ? w[8*(nbytes-1-j) +: 8] : w[8*j +: 8];
      sum = sum + b;
      exp_q.push_back(b);
    end
    if (frame) exp_q.push_back(sum);
  endtask

  task automatic offer(input int which, input logic [31:0] w);
    case (which)
      1:       begin b_d = w[15:0]; b_vld = 1'b1; end
      2:       begin c_d = w;       c_vld = 1'b1; end
      default: begin a_d = w[15:0]; a_vld = 1'b1; end
    endcase
  endtask

  task automatic idle_in();
    a_vld = 1'b0;
    b_vld = 1'b0;
    c_vld = 1'b0;
  endtask

  // Called just after the accepting edge with the FSM idle and FIFO empty.
  task automatic measure(input string tag, input int exp_cyc);
    int k;
    step();
    chk({tag, "_load_high"}, tx_m, 1);
    step();
    chk({tag, "_start_lat"}, tx_m, 0);
    k = 0;
    while (done_m !== 1'b1 && k < 1000) begin
      step();
      k++;
    end
    chk({tag, "_cycles"}, k, exp_cyc);
    chk({tag, "_done_tx"}, tx_m, 1);
    step();
    chk({tag, "_done_pulse"}, done_m, 0);
  endtask

  // Samples each bit at its centre, counting from the first low sample.
  always @(negedge clk_sys) begin
    if (done_m === 1'b1) n_done++;
    if (!mon_en) mon_busy = 1'b0;
    else if (!mon_busy) begin
      if (tx_m === 1'b0) begin
        mon_busy = 1'b1;
        mon_cyc  = 0;
      end
    end else mon_cyc++;
    if (mon_en && mon_busy && mon_cyc > 0) begin
      if (mon_cyc == baud_m / 2 + 0 && mon_cyc < baud_m)
        chk("rx_start", tx_m, 0);
      else if (mon_cyc < 9 * baud_m && (mon_cyc - baud_m / 2) % baud_m == 0)
        rx_byte = {tx_m, rx_byte[7:1]};
      else if (mon_cyc == 9 * baud_m + baud_m / 2) begin
        chk("rx_stop", tx_m, 1);
        chk("rx_byte", {56'h0, rx_byte}, (exp_q.size() > 0) ? {56'h0, exp_q.pop_front()} : 64'h100);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    int base;
    int lows;
    int k;
    rst = 1'b1; ovf_clr = 1'b0;
    a_d = '0; b_d = '0; c_d = '0;
    idle_in();
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_tx", a_tx, 1);
    chk("rst_done", a_done, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_rdy", a_rdy, 1);
    chk("rst_ovf", a_ovf, 0);
    mon_en = 1'b1;

    // Single framed word, MSB first.
    sel = 0; baud_m = 4; base = n_done;
    push_word(32'h1234, 2, 1'b1, 1'b1);
    offer(0, 32'h1234); step(); idle_in();
    chk("t1_cnt", a_cnt, 1);
    measure("t1", 160);
    chk("t1_left", exp_q.size(), 0);
    chk("t1_ndone", n_done - base, 1);

    // Unframed, LSB first.
    sel = 1; baud_m = 4; base = n_done;
    push_word(32'hBEEF, 2, 1'b0, 1'b0);
    offer(1, 32'hBEEF); step(); idle_in();
    measure("t2", 80);
    chk("t2_left", exp_q.size(), 0);
    chk("t2_ndone", n_done - base, 1);

    // Checksum wraps modulo 256.
    sel = 0; baud_m = 4;
    push_word(32'hFF02, 2, 1'b1, 1'b1);
    offer(0, 32'hFF02); step(); idle_in();
    measure("t3", 160);
    chk("t3_left", exp_q.size(), 0);

    // Six back-to-back words into a depth-4 FIFO: the sixth is dropped.
    base = n_done;
    for (int i = 0; i < 6; i++) begin
      offer(0, 32'h0102 + 32'(i) * 32'h0202);
      if (i < 5) push_word(32'h0102 + 32'(i) * 32'h0202, 2, 1'b1, 1'b1);
      else chk("t4_rdy_full", a_rdy, 0);
      step();
    end
    idle_in();
    chk("t4_ovf_set", a_ovf, 1);
    chk("t4_cnt_full", a_cnt, 4);
    repeat (3) step();
    chk("t4_ovf_sticky", a_ovf, 1);
    offer(0, 32'hDEAD); ovf_clr = 1'b1; step();
    chk("t4_clr_prio", a_ovf, 0);
    ovf_clr = 1'b0; step();
    chk("t4_ovf_again", a_ovf, 1);
    idle_in(); ovf_clr = 1'b1; step();
    chk("t4_ovf_clr", a_ovf, 0);
    ovf_clr = 1'b0;
    k = 0;
    while (n_done - base < 5 && k < 3000) begin
      step();
      k++;
    end
    chk("t4_frames", n_done - base, 5);
    chk("t4_left", exp_q.size(), 0);
    chk("t4_cnt_empty", a_cnt, 0);
    repeat (5) step();

    // Reset during a data bit of the second byte with two words queued.
    base = n_done;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 3; i++) begin
      offer(0, 32'h1111 * 32'(i + 1));
      step();
    end
    idle_in();
    repeat (50) step();
    chk("t5_queued", a_cnt, 2);
    mon_en = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_tx", a_tx, 1);
    chk("t5_cnt", a_cnt, 0);
    chk("t5_rdy", a_rdy, 1);
    chk("t5_done", a_done, 0);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (a_tx !== 1'b1) lows++;
    end
    chk("t5_line_idle", lows, 0);
    chk("t5_no_done", n_done - base, 0);
    chk("t5_hdr_seen", exp_q.size(), 0);
    exp_q.delete();
    mon_en = 1'b1;

    // 32-bit word at the minimum baud divider.
    sel = 2; baud_m = 2; base = n_done;
    push_word(32'h01020304, 4, 1'b1, 1'b1);
    offer(2, 32'h01020304); step(); idle_in();
    measure("t6", 120);
    chk("t6_left", exp_q.size(), 0);
    chk("t6_ndone", n_done - base, 1);

    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
